// File: rtl/cp_rf_write_arbiter.sv
// cp_rf_write_arbiter: shares the single CP register-file write port among the
// WB stage, the long-latency return path (buffered in a small FIFO) and the
// debug/host port. A starvation FSM requests a pipeline stall so the FIFO
// can drain when WB keeps winning.
module cp_rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          iClk,
  input  logic                          iReset_n,
  input  logic                          iWB_Write_Valid,
  input  logic [ADDR_WIDTH-1:0]         iWB_Write_Addr,
  input  logic [DATA_WIDTH-1:0]         iWB_Write_Data,
  input  logic                          iLR_Valid,
  output logic                          oLR_Ready,
  input  logic [ADDR_WIDTH-1:0]         iLR_Addr,
  input  logic [DATA_WIDTH-1:0]         iLR_Data,
  input  logic                          iDbg_Req,
  input  logic [ADDR_WIDTH-1:0]         iDbg_Addr,
  input  logic [DATA_WIDTH-1:0]         iDbg_Data,
  output logic                          oDbg_Ack,
  output logic                          oRF_Write_Enable,
  output logic [ADDR_WIDTH-1:0]         oRF_Write_Addr,
  output logic [DATA_WIDTH-1:0]         oRF_Write_Data,
  output logic                          oStall_Req,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_Count
);

  localparam int unsigned PtrWidth    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntWidth    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StRun, StStall} stateT;

  logic [ADDR_WIDTH-1:0]  fifoAddr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifoData [FIFO_DEPTH];
  logic [PtrWidth-1:0]    wrPtrQ, rdPtrQ;
  logic [CntWidth-1:0]    countQ;
  logic [StarveWidth-1:0] starveCntQ;
  stateT                  stateQ;
  logic                   stallQ;

  logic fifoEmpty, fifoFull, push, pop;

  assign fifoEmpty = (countQ == '0);
  assign fifoFull  = (countQ == CntWidth'(FIFO_DEPTH));
  // Conservative ready: a full FIFO refuses even if a pop happens this cycle.
  assign oLR_Ready = iReset_n && !fifoFull;
  assign push      = iLR_Valid && oLR_Ready;

  // Fixed-priority grant: WB, then FIFO head, then debug. Address 0 is
  // consumed but never written.
  always_comb begin
    oRF_Write_Enable = 1'b0;
    oRF_Write_Addr   = '0;
    oRF_Write_Data   = '0;
    oDbg_Ack         = 1'b0;
    pop              = 1'b0;
    if (iReset_n) begin
      if (iWB_Write_Valid) begin
        oRF_Write_Addr   = iWB_Write_Addr;
        oRF_Write_Data   = iWB_Write_Data;
        oRF_Write_Enable = (iWB_Write_Addr != '0);
      end else if (!fifoEmpty) begin
        pop              = 1'b1;
        oRF_Write_Addr   = fifoAddr[rdPtrQ];
        oRF_Write_Data   = fifoData[rdPtrQ];
        oRF_Write_Enable = (fifoAddr[rdPtrQ] != '0);
      end else if (iDbg_Req) begin
        oDbg_Ack         = 1'b1;
        oRF_Write_Addr   = iDbg_Addr;
        oRF_Write_Data   = iDbg_Data;
        oRF_Write_Enable = (iDbg_Addr != '0);
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge iClk) begin
    if (push) begin
      fifoAddr[wrPtrQ] <= iLR_Addr;
      fifoData[wrPtrQ] <= iLR_Data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + PtrWidth'(1);
      if (pop)  rdPtrQ <= rdPtrQ + PtrWidth'(1);
      unique case ({push, pop})
        2'b10:   countQ <= countQ + CntWidth'(1);
        2'b01:   countQ <= countQ - CntWidth'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // Starvation FSM: count blocked cycles, request a stall until the FIFO drains.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      stateQ     <= StRun;
      starveCntQ <= '0;
      stallQ     <= 1'b0;
    end else begin
      case (stateQ)
        StRun: begin
          if (!fifoEmpty && !pop) begin
            if (starveCntQ == StarveWidth'(STARVE_LIMIT - 1)) begin
              stateQ     <= StStall;
              stallQ     <= 1'b1;
              starveCntQ <= '0;
            end else begin
              starveCntQ <= starveCntQ + StarveWidth'(1);
            end
          end else begin
            starveCntQ <= '0;
          end
        end
        StStall: begin
          if (fifoEmpty) begin
            stateQ     <= StRun;
            stallQ     <= 1'b0;
            starveCntQ <= '0;
          end
        end
        default: begin
          stateQ     <= StRun;
          stallQ     <= 1'b0;
          starveCntQ <= '0;
        end
      endcase
    end
  end

  assign oStall_Req  = stallQ;
  assign oFIFO_Count = countQ;

endmodule

// File: tb/tb_cp_rf_write_arbiter.sv
// Bench for cp_rf_write_arbiter: directed scenarios plus randomized
// three-source traffic checked against a queue-based reference model.
module tb_cp_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int SL = 4;
  localparam int CW = $clog2(D) + 1;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic          iWB_Write_Valid;
  logic [AW-1:0] iWB_Write_Addr;
  logic [DW-1:0] iWB_Write_Data;
  logic          iLR_Valid;
  logic          oLR_Ready;
  logic [AW-1:0] iLR_Addr;
  logic [DW-1:0] iLR_Data;
  logic          iDbg_Req;
  logic [AW-1:0] iDbg_Addr;
  logic [DW-1:0] iDbg_Data;
  logic          oDbg_Ack;
  logic          oRF_Write_Enable;
  logic [AW-1:0] oRF_Write_Addr;
  logic [DW-1:0] oRF_Write_Data;
  logic          oStall_Req;
  logic [CW-1:0] oFIFO_Count;

  int nCmp = 0;
  int nBad = 0;

  cp_rf_write_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (D),
    .STARVE_LIMIT(SL)
  ) dut (
    .iClk            (iClk),
    .iReset_n        (iReset_n),
    .iWB_Write_Valid (iWB_Write_Valid),
    .iWB_Write_Addr  (iWB_Write_Addr),
    .iWB_Write_Data  (iWB_Write_Data),
    .iLR_Valid       (iLR_Valid),
    .oLR_Ready       (oLR_Ready),
    .iLR_Addr        (iLR_Addr),
    .iLR_Data        (iLR_Data),
    .iDbg_Req        (iDbg_Req),
    .iDbg_Addr       (iDbg_Addr),
    .iDbg_Data       (iDbg_Data),
    .oDbg_Ack        (oDbg_Ack),
    .oRF_Write_Enable(oRF_Write_Enable),
    .oRF_Write_Addr  (oRF_Write_Addr),
    .oRF_Write_Data  (oRF_Write_Data),
    .oStall_Req      (oStall_Req),
    .oFIFO_Count     (oFIFO_Count)
  );

  always #5 iClk = ~iClk;

  task automatic setIdle();
    iWB_Write_Valid = 1'b0; iWB_Write_Addr = '0; iWB_Write_Data = '0;
    iLR_Valid = 1'b0; iLR_Addr = '0; iLR_Data = '0;
    iDbg_Req = 1'b0; iDbg_Addr = '0; iDbg_Data = '0;
  endtask

  task automatic tick();
    @(posedge iClk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic doReset();
    setIdle();
    iReset_n = 1'b0;
    tick(); tick();
    iReset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    setIdle();
    iReset_n = 1'b0;
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd3; iWB_Write_Data = 32'h1234;
    #3;
    nCmp++;
    if (oFIFO_Count !== '0 || oStall_Req !== 1'b0 || oLR_Ready !== 1'b0 ||
        oRF_Write_Enable !== 1'b0 || oDbg_Ack !== 1'b0) begin
      nBad++;
      $display("FAIL reset_state: cnt=%0d stall=%b rdy=%b en=%b ack=%b want 0 0 0 0 0",
               oFIFO_Count, oStall_Req, oLR_Ready, oRF_Write_Enable, oDbg_Ack);
    end
    tick(); tick();
    setIdle();
    iReset_n = 1'b1;
    settle();
    nCmp++;
    if (oLR_Ready !== 1'b1 || oFIFO_Count !== '0 || oStall_Req !== 1'b0 ||
        oRF_Write_Enable !== 1'b0) begin
      nBad++;
      $display("FAIL reset_release: rdy=%b cnt=%0d stall=%b en=%b want 1 0 0 0",
               oLR_Ready, oFIFO_Count, oStall_Req, oRF_Write_Enable);
    end
    tick();
  endtask

  task automatic test_wb_only();
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd3; iWB_Write_Data = 32'hDEADBEEF;
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b1 || oRF_Write_Addr !== 5'd3 ||
        oRF_Write_Data !== 32'hDEADBEEF) begin
      nBad++;
      $display("FAIL wb_write: en=%b addr=%0d data=%h want 1 3 deadbeef",
               oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
    iWB_Write_Addr = 5'd0; iWB_Write_Data = 32'hCAFEF00D;
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b0 || oRF_Write_Addr !== 5'd0) begin
      nBad++;
      $display("FAIL wb_addr0: en=%b addr=%0d want 0 0", oRF_Write_Enable, oRF_Write_Addr);
    end
    tick();
    setIdle();
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b0 || oRF_Write_Addr !== '0 || oRF_Write_Data !== '0) begin
      nBad++;
      $display("FAIL idle_outputs: en=%b addr=%0d data=%h want 0 0 0",
               oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
  endtask

  task automatic test_contention();
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd1; iWB_Write_Data = 32'hAAAA;
    iLR_Valid = 1'b1; iLR_Addr = 5'd5; iLR_Data = 32'h11;
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b1 || oRF_Write_Addr !== 5'd1 || oLR_Ready !== 1'b1) begin
      nBad++;
      $display("FAIL cont_wb_first: en=%b addr=%0d rdy=%b want 1 1 1",
               oRF_Write_Enable, oRF_Write_Addr, oLR_Ready);
    end
    tick();
    iLR_Addr = 5'd6; iLR_Data = 32'h22;
    tick();
    iLR_Valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      nCmp++;
      if (oFIFO_Count !== 2 || oLR_Ready !== 1'b0 || oStall_Req !== 1'b0) begin
        nBad++;
        $display("FAIL cont_blocked%0d: cnt=%0d rdy=%b stall=%b want 2 0 0",
                 k, oFIFO_Count, oLR_Ready, oStall_Req);
      end
      tick();
    end
    settle();
    nCmp++;
    if (oStall_Req !== 1'b1) begin
      nBad++;
      $display("FAIL cont_stall_on: stall=%b want 1", oStall_Req);
    end
    iWB_Write_Valid = 1'b0;
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b1 || oRF_Write_Addr !== 5'd5 || oRF_Write_Data !== 32'h11) begin
      nBad++;
      $display("FAIL cont_pop_r5: en=%b addr=%0d data=%h want 1 5 11",
               oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
    settle();
    nCmp++;
    if (oRF_Write_Enable !== 1'b1 || oRF_Write_Addr !== 5'd6 || oRF_Write_Data !== 32'h22 ||
        oStall_Req !== 1'b1) begin
      nBad++;
      $display("FAIL cont_pop_r6: en=%b addr=%0d data=%h stall=%b want 1 6 22 1",
               oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data, oStall_Req);
    end
    tick();
    settle();
    nCmp++;
    if (oFIFO_Count !== 0 || oStall_Req !== 1'b1 || oRF_Write_Enable !== 1'b0) begin
      nBad++;
      $display("FAIL cont_empty: cnt=%0d stall=%b en=%b want 0 1 0",
               oFIFO_Count, oStall_Req, oRF_Write_Enable);
    end
    tick();
    nCmp++;
    if (oStall_Req !== 1'b0) begin
      nBad++;
      $display("FAIL cont_stall_off: stall=%b want 0", oStall_Req);
    end
    setIdle();
    tick();
  endtask

  task automatic test_push_pop();
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd2; iWB_Write_Data = 32'h2;
    iLR_Valid = 1'b1; iLR_Addr = 5'd10; iLR_Data = 32'hA0;
    tick();
    iWB_Write_Valid = 1'b0;
    iLR_Addr = 5'd11; iLR_Data = 32'hB0;
    settle();
    nCmp++;
    if (oFIFO_Count !== 1 || oRF_Write_Addr !== 5'd10 || oRF_Write_Data !== 32'hA0) begin
      nBad++;
      $display("FAIL pp_head: cnt=%0d addr=%0d data=%h want 1 10 a0",
               oFIFO_Count, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
    iLR_Valid = 1'b0;
    settle();
    nCmp++;
    if (oFIFO_Count !== 1 || oRF_Write_Addr !== 5'd11 || oRF_Write_Data !== 32'hB0 ||
        oRF_Write_Enable !== 1'b1) begin
      nBad++;
      $display("FAIL pp_order: cnt=%0d addr=%0d data=%h en=%b want 1 11 b0 1",
               oFIFO_Count, oRF_Write_Addr, oRF_Write_Data, oRF_Write_Enable);
    end
    tick();
    nCmp++;
    if (oFIFO_Count !== 0) begin
      nBad++;
      $display("FAIL pp_drain: cnt=%0d want 0", oFIFO_Count);
    end
    setIdle();
    tick();
  endtask

  task automatic test_debug();
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd4; iWB_Write_Data = 32'h4;
    iLR_Valid = 1'b1; iLR_Addr = 5'd8; iLR_Data = 32'h88;
    iDbg_Req = 1'b1; iDbg_Addr = 5'd7; iDbg_Data = 32'h5A;
    settle();
    nCmp++;
    if (oDbg_Ack !== 1'b0) begin
      nBad++;
      $display("FAIL dbg_wb_blocks: ack=%b want 0", oDbg_Ack);
    end
    tick();
    iWB_Write_Valid = 1'b0; iLR_Valid = 1'b0;
    settle();
    nCmp++;
    if (oDbg_Ack !== 1'b0 || oRF_Write_Addr !== 5'd8 || oRF_Write_Data !== 32'h88) begin
      nBad++;
      $display("FAIL dbg_fifo_blocks: ack=%b addr=%0d data=%h want 0 8 88",
               oDbg_Ack, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
    settle();
    nCmp++;
    if (oDbg_Ack !== 1'b1 || oRF_Write_Enable !== 1'b1 || oRF_Write_Addr !== 5'd7 ||
        oRF_Write_Data !== 32'h5A) begin
      nBad++;
      $display("FAIL dbg_write: ack=%b en=%b addr=%0d data=%h want 1 1 7 5a",
               oDbg_Ack, oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data);
    end
    tick();
    iDbg_Addr = 5'd0; iDbg_Data = 32'h33;
    settle();
    nCmp++;
    if (oDbg_Ack !== 1'b1 || oRF_Write_Enable !== 1'b0) begin
      nBad++;
      $display("FAIL dbg_addr0: ack=%b en=%b want 1 0", oDbg_Ack, oRF_Write_Enable);
    end
    tick();
    setIdle();
    settle();
    nCmp++;
    if (oDbg_Ack !== 1'b0) begin
      nBad++;
      $display("FAIL dbg_ack_drop: ack=%b want 0", oDbg_Ack);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    iWB_Write_Valid = 1'b1; iWB_Write_Addr = 5'd9; iWB_Write_Data = 32'h9;
    iLR_Valid = 1'b1; iLR_Addr = 5'd5; iLR_Data = 32'h11;
    tick();
    iLR_Addr = 5'd6; iLR_Data = 32'h22;
    tick();
    iLR_Valid = 1'b0;
    tick(); tick(); tick();
    nCmp++;
    if (oFIFO_Count !== 2 || oStall_Req !== 1'b1) begin
      nBad++;
      $display("FAIL rstmid_pre: cnt=%0d stall=%b want 2 1", oFIFO_Count, oStall_Req);
    end
    settle();
    iReset_n = 1'b0;
    #1;
    nCmp++;
    if (oFIFO_Count !== 0 || oStall_Req !== 1'b0 || oRF_Write_Enable !== 1'b0 ||
        oLR_Ready !== 1'b0) begin
      nBad++;
      $display("FAIL rstmid_async: cnt=%0d stall=%b en=%b rdy=%b want 0 0 0 0",
               oFIFO_Count, oStall_Req, oRF_Write_Enable, oLR_Ready);
    end
    setIdle();
    tick();
    iReset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      nCmp++;
      if (oRF_Write_Enable !== 1'b0 || oFIFO_Count !== 0 || oLR_Ready !== 1'b1) begin
        nBad++;
        $display("FAIL rstmid_after%0d: en=%b cnt=%0d rdy=%b want 0 0 1",
                 k, oRF_Write_Enable, oFIFO_Count, oLR_Ready);
      end
      tick();
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entT;

  task automatic test_random();
    entT           q[$];
    int            blocked = 0;
    bit            mStall = 0;
    bit            dbgPend = 0;
    logic [AW-1:0] dA = '0;
    logic [DW-1:0] dD = '0;
    int            nCycles = 800;
    doReset();
    for (int i = 0; i < nCycles; i++) begin
      bit            drain = (i >= nCycles - 20);
      bit            expRdy, expPush, expPop, expAck, granted;
      logic [AW-1:0] eA;
      logic [DW-1:0] eD;
      int            preSize;
      iWB_Write_Valid = !drain && ($urandom_range(0, 99) < 55);
      iWB_Write_Addr  = AW'($urandom);
      iWB_Write_Data  = $urandom;
      iLR_Valid       = !drain && ($urandom_range(0, 1) == 1);
      iLR_Addr        = AW'($urandom);
      iLR_Data        = $urandom;
      if (!dbgPend && !drain && $urandom_range(0, 7) == 0) begin
        dbgPend = 1; dA = AW'($urandom); dD = $urandom;
      end
      iDbg_Req = dbgPend; iDbg_Addr = dA; iDbg_Data = dD;
      settle();

      preSize = q.size();
      expRdy  = (preSize < D);
      expPush = iLR_Valid && expRdy;
      expPop  = 0; expAck = 0; granted = 0; eA = '0; eD = '0;
      if (iWB_Write_Valid) begin
        granted = 1; eA = iWB_Write_Addr; eD = iWB_Write_Data;
      end else if (preSize > 0) begin
        granted = 1; expPop = 1; eA = q[0].a; eD = q[0].d;
      end else if (dbgPend) begin
        granted = 1; expAck = 1; eA = dA; eD = dD;
      end

      nCmp++;
      if (oRF_Write_Enable !== (granted && eA != 0) || oRF_Write_Addr !== eA ||
          oRF_Write_Data !== eD || oDbg_Ack !== expAck) begin
        nBad++;
        $display("FAIL rand_grant cyc=%0d: en=%b addr=%0d data=%h ack=%b want %b %0d %h %b",
                 i, oRF_Write_Enable, oRF_Write_Addr, oRF_Write_Data, oDbg_Ack,
                 (granted && eA != 0), eA, eD, expAck);
      end
      nCmp++;
      if (oLR_Ready !== expRdy || oFIFO_Count !== CW'(preSize) || oStall_Req !== mStall) begin
        nBad++;
        $display("FAIL rand_status cyc=%0d: rdy=%b cnt=%0d stall=%b want %b %0d %b",
                 i, oLR_Ready, oFIFO_Count, oStall_Req, expRdy, preSize, mStall);
      end

      // Starvation: SL consecutive cycles with entries waiting and none popped.
      if (mStall) begin
        if (preSize == 0) mStall = 0;
      end else if (preSize > 0 && !expPop) begin
        blocked++;
        if (blocked == SL) begin
          mStall = 1; blocked = 0;
        end
      end else begin
        blocked = 0;
      end
      if (expPop) void'(q.pop_front());
      if (expPush) q.push_back('{a: iLR_Addr, d: iLR_Data});
      if (expAck) dbgPend = 0;
      tick();
    end
    setIdle();
    nCmp++;
    if (oFIFO_Count !== CW'(q.size()) || q.size() != 0) begin
      nBad++;
      $display("FAIL rand_final: cnt=%0d model=%0d want 0", oFIFO_Count, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_push_pop();
    test_debug();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
